// File: rtl/rvp_pkg.sv
// Shared hazard-unit types and constants for the 5-stage rvp core.
// Register-usage tags, forwarding selects and the producer/consumer match rule.
package rvp_pkg;

    // Widest register index the shadow tags can carry. XREG_W must not exceed it.
    localparam int TAG_RW = 5;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef logic [TAG_RW-1:0] tag_reg_t;

    typedef struct packed {
        tag_reg_t rs1;
        tag_reg_t rs2;
        tag_reg_t rd;
        logic     rw;
        logic     ld;
        logic     mem;
    } haz_tag_t;

    typedef struct packed {
        tag_reg_t rd;
        logic     rw;
        logic     mem;
    } haz_mtag_t;

    typedef struct packed {
        tag_reg_t rd;
        logic     rw;
    } haz_wtag_t;

    localparam haz_tag_t TAG_BUBBLE = '0;

    // x0 is never a producer, so it can neither stall nor forward.
    function automatic logic reg_match(input tag_reg_t prod_rd, input logic prod_rw,
                                       input tag_reg_t src);
        return prod_rw && (prod_rd != '0) && (prod_rd == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input tag_reg_t src,
                                           input tag_reg_t m_rd, input logic m_rw,
                                           input tag_reg_t w_rd, input logic w_rw);
        if (reg_match(m_rd, m_rw, src)) return FWD_M;
        if (reg_match(w_rd, w_rw, src)) return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/haz_shadow_pipe.sv
// E/M/W register-usage tags tracking the real pipeline registers.
// Freeze holds every stage; a killed E slot loads a bubble.
module haz_shadow_pipe
    import rvp_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_freeze,
    input  logic      i_kill_e,
    input  haz_tag_t  i_tag_d,
    output haz_tag_t  o_e,
    output haz_mtag_t o_m,
    output haz_wtag_t o_w
);

    haz_tag_t  r_e;
    haz_mtag_t r_m;
    haz_wtag_t r_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e <= TAG_BUBBLE;
            r_m <= '0;
            r_w <= '0;
        end else if (!i_freeze) begin
            r_e     <= i_kill_e ? TAG_BUBBLE : i_tag_d;
            r_m.rd  <= r_e.rd;
            r_m.rw  <= r_e.rw;
            r_m.mem <= r_e.mem;
            r_w.rd  <= r_m.rd;
            r_w.rw  <= r_m.rw;
        end
    end

    assign o_e = r_e;
    assign o_m = r_m;
    assign o_w = r_w;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush/freeze sequencing and EX operand forwarding.
// Define HAZARD_FORWARD_EN for M/W forwarding; otherwise RAW hazards stall until the producer reaches W.
module hazard_ctrl
    import rvp_pkg::*;
#(
    parameter int XREG_W = 5
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_d,
    input  logic [XREG_W-1:0] rs1_d,
    input  logic [XREG_W-1:0] rs2_d,
    input  logic [XREG_W-1:0] rd_d,
    input  logic              reg_write_d,
    input  logic [1:0]        result_src_d,
    input  logic              mem_write_d,
    input  logic              pc_src_e,
    input  logic              dmem_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              freeze,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e
);

    haz_tag_t  w_tag_d;
    haz_tag_t  w_e;
    haz_mtag_t w_m;
    haz_wtag_t w_w;
    tag_reg_t  w_rs1_d;
    tag_reg_t  w_rs2_d;
    logic      w_kill_e;
    logic      w_mem_wait;
    logic      w_raw;

    assign w_rs1_d = tag_reg_t'(rs1_d);
    assign w_rs2_d = tag_reg_t'(rs2_d);

    // Loads also occupy the data memory, so they count as memory ops for the wait.
    always_comb begin
        w_tag_d     = TAG_BUBBLE;
        w_tag_d.rs1 = w_rs1_d;
        w_tag_d.rs2 = w_rs2_d;
        w_tag_d.rd  = tag_reg_t'(rd_d);
        w_tag_d.rw  = reg_write_d;
        w_tag_d.ld  = (result_src_d == RES_LOAD);
        w_tag_d.mem = (result_src_d == RES_LOAD) | mem_write_d;
    end

    assign w_kill_e = flush_e | ~valid_d;

    haz_shadow_pipe u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_freeze (freeze),
        .i_kill_e (w_kill_e),
        .i_tag_d  (w_tag_d),
        .o_e      (w_e),
        .o_m      (w_m),
        .o_w      (w_w)
    );

    assign w_mem_wait = w_m.mem & ~dmem_ready;

`ifdef HAZARD_FORWARD_EN
    assign w_raw = valid_d & w_e.ld &
                   (reg_match(w_e.rd, w_e.rw, w_rs1_d) | reg_match(w_e.rd, w_e.rw, w_rs2_d));

    assign fwd_a_e = fwd_sel(w_e.rs1, w_m.rd, w_m.rw, w_w.rd, w_w.rw);
    assign fwd_b_e = fwd_sel(w_e.rs2, w_m.rd, w_m.rw, w_w.rd, w_w.rw);
`else
    // No bypass: hold D while its source is still in E or M; W is covered by the regfile write-first.
    assign w_raw = valid_d &
                   (reg_match(w_e.rd, w_e.rw, w_rs1_d) | reg_match(w_e.rd, w_e.rw, w_rs2_d) |
                    reg_match(w_m.rd, w_m.rw, w_rs1_d) | reg_match(w_m.rd, w_m.rw, w_rs2_d));

    assign fwd_a_e = FWD_RF;
    assign fwd_b_e = FWD_RF;
`endif

    // Freeze > redirect > RAW stall; a frozen EX keeps pc_src_e so the redirect replays.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        freeze  = 1'b0;
        if (w_mem_wait) begin
            freeze  = 1'b1;
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (w_raw) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Not every tag field is consumed in every build.
    logic w_unused_tags;
    assign w_unused_tags = ^{w_e, w_m, w_w};

endmodule
